// File: rtl/rv_io_pkg.sv
// Shared types and constants for the rv32 I/O bridge: reset sequencer states,
// default stream/FIFO sizing and the FIFO pointer-width helper.
package rv_io_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } rst_state_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 16;

    // Index bits needed to address 'depth' entries; the FIFO adds one wrap bit on top.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rv_io_fifo.sv
// Synchronous first-word-visible FIFO with valid/ready on both sides and a
// synchronous flush; pointers carry an extra wrap bit to tell full from empty.
module rv_io_fifo
    import rv_io_pkg::*;
#(
    parameter int WIDTH = DEF_DATA_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_ready
);

    localparam int PW = ptr_w(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_empty = (r_wr_ptr == r_rd_ptr);

    // Ready looks only at the registered pointers, never at a same-cycle pop.
    assign o_ready = ~w_full;
    assign o_valid = ~w_empty;
    assign o_data  = r_mem[r_rd_ptr[PW-1:0]];

    assign w_push = i_valid & ~w_full;
    assign w_pop  = i_ready & ~w_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
    end

endmodule

// File: rtl/rv_io_bridge.sv
// I/O glue between the rv32 core, a CLK-synchronous UART endpoint and an LED bank:
// lock-gated core reset sequencer, TX/RX FIFOs and a masked LED register.
// Optional TX->RX loopback when RV_IO_BRIDGE_LOOPBACK_EN is defined.
module rv_io_bridge
    import rv_io_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int TX_DEPTH = DEF_DEPTH,
    parameter int RX_DEPTH = DEF_DEPTH,
    parameter int NUM_LEDS = 1,
    parameter int RST_HOLD = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                pll_locked,
    output logic                core_rst_n,
`ifdef RV_IO_BRIDGE_LOOPBACK_EN
    input  logic                loopback_sel,
`endif
    input  logic                core_tx_valid,
    input  logic [DATA_W-1:0]   core_tx_data,
    output logic                core_tx_ready,
    input  logic                core_rx_ready,
    output logic                core_rx_valid,
    output logic [DATA_W-1:0]   core_rx_data,
    input  logic                led_wr_valid,
    input  logic [NUM_LEDS-1:0] led_wr_data,
    input  logic [NUM_LEDS-1:0] led_wr_mask,
    output logic [NUM_LEDS-1:0] led_out,
    output logic                uart_in_valid,
    output logic [DATA_W-1:0]   uart_in_data,
    input  logic                uart_in_ready,
    input  logic                uart_out_valid,
    input  logic [DATA_W-1:0]   uart_out_data,
    output logic                uart_out_ready
);

    localparam int CNT_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_HOLD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    rst_state_t          r_state;
    rst_state_t          w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                r_core_rst_n;
    logic [NUM_LEDS-1:0] r_led;
    logic                w_run;
    logic                w_flush;

    logic                w_tx_in_valid;
    logic                w_tx_in_ready;
    logic                w_tx_out_valid;
    logic [DATA_W-1:0]   w_tx_out_data;
    logic                w_tx_out_ready;
    logic                w_rx_in_valid;
    logic [DATA_W-1:0]   w_rx_in_data;
    logic                w_rx_in_ready;
    logic                w_rx_out_valid;
    logic [DATA_W-1:0]   w_rx_out_data;
    logic                w_rx_out_ready;
    logic                w_lb;

    // Reset sequencer: HOLD counts RST_HOLD-1 down to 0, giving RST_HOLD low cycles.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= WAIT_LOCK;
            r_cnt        <= '0;
            r_core_rst_n <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_core_rst_n <= (w_state_nxt == RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            WAIT_LOCK: begin
                if (pll_locked) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = CNT_LOAD;
                end
            end
            HOLD: begin
                if (!pll_locked)          w_state_nxt = WAIT_LOCK;
                else if (r_cnt == '0)     w_state_nxt = RUN;
                else                      w_cnt_nxt   = r_cnt - CNT_ONE;
            end
            RUN: begin
                if (!pll_locked) w_state_nxt = WAIT_LOCK;
            end
            default: w_state_nxt = WAIT_LOCK;
        endcase
    end

    assign core_rst_n = r_core_rst_n;
    assign w_run      = (r_state == RUN);
    assign w_flush    = ~w_run;

    always_ff @(posedge CLK) begin
        if (RST)               r_led <= '0;
        else if (led_wr_valid) r_led <= (r_led & ~led_wr_mask) | (led_wr_data & led_wr_mask);
    end

    assign led_out = r_led;

`ifdef RV_IO_BRIDGE_LOOPBACK_EN
    logic r_lb;

    // Loopback selection is registered so a switch lands on a clean cycle boundary.
    always_ff @(posedge CLK) begin
        if (RST) r_lb <= 1'b0;
        else     r_lb <= loopback_sel;
    end

    assign w_lb           = r_lb;
    assign w_tx_out_ready = w_run & (w_lb ? w_rx_in_ready : uart_in_ready);
    assign w_rx_in_valid  = w_run & (w_lb ? w_tx_out_valid : uart_out_valid);
    assign w_rx_in_data   = w_lb ? w_tx_out_data : uart_out_data;
`else
    assign w_lb           = 1'b0;
    assign w_tx_out_ready = w_run & uart_in_ready;
    assign w_rx_in_valid  = w_run & uart_out_valid;
    assign w_rx_in_data   = uart_out_data;
`endif

    assign w_tx_in_valid  = w_run & core_tx_valid;
    assign w_rx_out_ready = w_run & core_rx_ready;

    assign core_tx_ready  = w_run & w_tx_in_ready;
    assign uart_in_valid  = w_run & ~w_lb & w_tx_out_valid;
    assign uart_in_data   = w_tx_out_data;
    assign uart_out_ready = w_run & ~w_lb & w_rx_in_ready;
    assign core_rx_valid  = w_run & w_rx_out_valid;
    assign core_rx_data   = w_rx_out_data;

    rv_io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (w_flush),
        .i_valid (w_tx_in_valid),
        .i_data  (core_tx_data),
        .o_ready (w_tx_in_ready),
        .o_valid (w_tx_out_valid),
        .o_data  (w_tx_out_data),
        .i_ready (w_tx_out_ready)
    );

    rv_io_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (RX_DEPTH)
    ) u_rx_fifo (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_flush (w_flush),
        .i_valid (w_rx_in_valid),
        .i_data  (w_rx_in_data),
        .o_ready (w_rx_in_ready),
        .o_valid (w_rx_out_valid),
        .o_data  (w_rx_out_data),
        .i_ready (w_rx_out_ready)
    );

endmodule

// File: tb/tb_rv_io_bridge.sv
// Directed bench for rv_io_bridge: reset/lock sequencing, TX burst, RX full
// push/pop with pointer wrap, LED masking, lock loss and optional loopback.
module tb_rv_io_bridge;

    logic       CLK = 1'b0;
    logic       RST;
    logic       pll_locked;
    logic       core_rst_n;
`ifdef RV_IO_BRIDGE_LOOPBACK_EN
    logic       loopback_sel;
`endif
    logic       core_tx_valid;
    logic [7:0] core_tx_data;
    logic       core_tx_ready;
    logic       core_rx_ready;
    logic       core_rx_valid;
    logic [7:0] core_rx_data;
    logic       led_wr_valid;
    logic [3:0] led_wr_data;
    logic [3:0] led_wr_mask;
    logic [3:0] led_out;
    logic       uart_in_valid;
    logic [7:0] uart_in_data;
    logic       uart_in_ready;
    logic       uart_out_valid;
    logic [7:0] uart_out_data;
    logic       uart_out_ready;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    rv_io_bridge #(
        .DATA_W   (8),
        .TX_DEPTH (16),
        .RX_DEPTH (16),
        .NUM_LEDS (4),
        .RST_HOLD (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .pll_locked     (pll_locked),
        .core_rst_n     (core_rst_n),
`ifdef RV_IO_BRIDGE_LOOPBACK_EN
        .loopback_sel   (loopback_sel),
`endif
        .core_tx_valid  (core_tx_valid),
        .core_tx_data   (core_tx_data),
        .core_tx_ready  (core_tx_ready),
        .core_rx_ready  (core_rx_ready),
        .core_rx_valid  (core_rx_valid),
        .core_rx_data   (core_rx_data),
        .led_wr_valid   (led_wr_valid),
        .led_wr_data    (led_wr_data),
        .led_wr_mask    (led_wr_mask),
        .led_out        (led_out),
        .uart_in_valid  (uart_in_valid),
        .uart_in_data   (uart_in_data),
        .uart_in_ready  (uart_in_ready),
        .uart_out_valid (uart_out_valid),
        .uart_out_data  (uart_out_data),
        .uart_out_ready (uart_out_ready)
    );

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int acc;
        int nrx;
        logic [7:0] rx_seen [4];

        RST = 1'b1; pll_locked = 1'b0;
        core_tx_valid = 1'b0; core_tx_data = '0; core_rx_ready = 1'b0;
        led_wr_valid = 1'b0; led_wr_data = '0; led_wr_mask = '0;
        uart_in_ready = 1'b0; uart_out_valid = 1'b0; uart_out_data = '0;
`ifdef RV_IO_BRIDGE_LOOPBACK_EN
        loopback_sel = 1'b0;
`endif
        tick(3);
        check("rst_core_rst_n", core_rst_n, 0);
        check("rst_led", led_out, 0);
        check("rst_tx_ready", core_tx_ready, 0);
        check("rst_uart_out_ready", uart_out_ready, 0);
        check("rst_rx_valid", core_rx_valid, 0);
        check("rst_uart_in_valid", uart_in_valid, 0);

        // Out of reset but no lock: core stays in reset.
        RST = 1'b0;
        tick(6);
        check("nolock_core_rst_n", core_rst_n, 0);
        check("nolock_tx_ready", core_tx_ready, 0);

        // Lock seen at next edge, then exactly 8 more edges until release.
        pll_locked = 1'b1;
        tick(8);
        check("hold_core_rst_n", core_rst_n, 0);
        tick(1);
        check("run_core_rst_n", core_rst_n, 1);
        check("run_tx_ready", core_tx_ready, 1);
        check("run_uart_out_ready", uart_out_ready, 1);

        // TX burst of 20 into a blocked UART: 16 accepted.
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            core_tx_valid = 1'b1;
            core_tx_data  = 8'(i);
            if (i == 16) check("tx_ready_at_17th", core_tx_ready, 0);
            if (core_tx_ready) acc++;
            tick(1);
        end
        core_tx_valid = 1'b0;
        check("tx_accepted", acc, 16);
        check("tx_full_ready", core_tx_ready, 0);
        check("tx_head_valid", uart_in_valid, 1);
        uart_in_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            check("tx_drain_valid", uart_in_valid, 1);
            check("tx_drain_data", uart_in_data, j);
            tick(1);
        end
        check("tx_empty", uart_in_valid, 0);
        check("tx_ready_again", core_tx_ready, 1);
        uart_in_ready = 1'b0;

        // Move RX pointers off zero so the full fill wraps.
        for (int i = 0; i < 5; i++) begin
            uart_out_valid = 1'b1; uart_out_data = 8'(8'h30 + i);
            tick(1);
        end
        uart_out_valid = 1'b0;
        core_rx_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("rx_pre_data", core_rx_data, 8'h30 + i);
            tick(1);
        end
        core_rx_ready = 1'b0;
        check("rx_pre_empty", core_rx_valid, 0);

        for (int i = 0; i < 16; i++) begin
            uart_out_valid = 1'b1; uart_out_data = 8'(8'h40 + i);
            tick(1);
        end
        check("rx_full_ready", uart_out_ready, 0);
        check("rx_full_head", core_rx_data, 8'h40);
        // Simultaneous pop and offered push while full.
        uart_out_data = 8'h50; core_rx_ready = 1'b1;
        check("rx_simul_ready", uart_out_ready, 0);
        tick(1);
        core_rx_ready = 1'b0;
        check("rx_after_pop_ready", uart_out_ready, 1);
        check("rx_after_pop_head", core_rx_data, 8'h41);
        tick(1);
        uart_out_valid = 1'b0;
        check("rx_refull_ready", uart_out_ready, 0);
        core_rx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("rx_drain_valid", core_rx_valid, 1);
            check("rx_drain_data", core_rx_data, 8'h41 + k);
            tick(1);
        end
        core_rx_ready = 1'b0;
        check("rx_empty", core_rx_valid, 0);

        // LED masked writes.
        led_wr_valid = 1'b1; led_wr_data = 4'b1111; led_wr_mask = 4'b0101;
        tick(1);
        check("led_w1", led_out, 4'b0101);
        led_wr_data = 4'b0000; led_wr_mask = 4'b0100;
        tick(1);
        led_wr_valid = 1'b0;
        check("led_w2", led_out, 4'b0001);

        // Lock loss with a byte pending in TX.
        core_tx_valid = 1'b1; core_tx_data = 8'h77;
        tick(1);
        core_tx_valid = 1'b0;
        check("pend_valid", uart_in_valid, 1);
        pll_locked = 1'b0;
        tick(1);
        check("unlock_core_rst_n", core_rst_n, 0);
        check("unlock_uart_in_valid", uart_in_valid, 0);
        check("unlock_tx_ready", core_tx_ready, 0);
        tick(1);
        check("unlock_led_kept", led_out, 4'b0001);
        pll_locked = 1'b1;
        tick(9);
        check("relock_core_rst_n", core_rst_n, 1);
        check("relock_flushed", uart_in_valid, 0);
        check("relock_rx_empty", core_rx_valid, 0);

`ifdef RV_IO_BRIDGE_LOOPBACK_EN
        loopback_sel = 1'b1; core_rx_ready = 1'b1; uart_in_ready = 1'b1;
        tick(1);
        nrx = 0;
        for (int c = 0; c < 10; c++) begin
            core_tx_valid = (c < 2);
            core_tx_data  = (c == 0) ? 8'hA5 : 8'h3C;
            check("lb_no_uart", uart_in_valid, 0);
            if (core_rx_valid && nrx < 4) begin
                rx_seen[nrx] = core_rx_data;
                nrx++;
            end
            tick(1);
        end
        core_tx_valid = 1'b0;
        check("lb_count", nrx, 2);
        check("lb_byte0", rx_seen[0], 8'hA5);
        check("lb_byte1", rx_seen[1], 8'h3C);
        loopback_sel = 1'b0; core_rx_ready = 1'b0; uart_in_ready = 1'b0;
`else
        nrx = 0;
        rx_seen[0] = 8'h00;
`endif

        // LED writes are ignored while RST is high.
        RST = 1'b1;
        led_wr_valid = 1'b1; led_wr_data = 4'b1111; led_wr_mask = 4'b1111;
        tick(1);
        led_wr_valid = 1'b0;
        check("rst_led_write_ignored", led_out, 0);
        check("rst_again_core_rst_n", core_rst_n, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
